// File: rtl/flip_cmd_pkg.sv
// Shared definitions for the flip-stage command sequencer: op codes, FSM
// states and the flip-stage next-state rule used by the RTL and its bench.
package flip_cmd_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_LOAD0  = 2'b10;
  localparam logic [1:0] OP_LOAD1  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_t;

  // Next q2 of the two-phase flip stage given its sampled b1/b2 controls.
  function automatic logic flip_next(input logic q, input logic b1, input logic b2);
    if (b2)
      return b1;
    else if (b1)
      return ~q;
    else
      return q;
  endfunction

endpackage

// File: rtl/flip_cmd_seq_if.sv
// Producer-side command handshake of flip_cmd_seq.
interface flip_cmd_seq_if #(
  parameter int LEN_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/flip_cmd_fifo.sv
// Small command FIFO: registered storage, head presented combinationally,
// no bypass (full is derived from the stored count only).
module flip_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("flip_cmd_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/flip_cmd_seq.sv
// Replays queued {b2,b1} operations for their hold length, tracks the
// downstream flip stage's q2 and counts completed commands.
module flip_cmd_seq
  import flip_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  flip_cmd_seq_if.slave        cmd,
  output logic                 b1,
  output logic                 b2,
  output logic                 busy,
  output logic                 exp_q,
  output logic [7:0]           done_cnt
);

  localparam int W = 2 + LEN_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [W-1:0]     head;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] head_remain;

  state_t           state_q, state_d;
  logic [1:0]       b_q, b_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [7:0]       done_q, done_d;
  logic             expq_q, expq_d;

  flip_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid),
    .pop   (fifo_pop),
    .wdata ({cmd.cmd_op, cmd.cmd_len}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd.cmd_ready = !fifo_full;
  assign head_op       = head[W-1:LEN_W];
  assign head_len      = head[LEN_W-1:0];
  // Length 0 behaves as 1, so both load a zero remaining count.
  assign head_remain   = (head_len == '0) ? '0 : head_len - 1'b1;

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    remain_d = remain_q;
    done_d   = done_q;
    fifo_pop = 1'b0;
    expq_d   = flip_next(expq_q, b_q[0], b_q[1]);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_DRIVE;
          b_d      = head_op;
          remain_d = head_remain;
        end
      end
      ST_DRIVE: begin
        if (remain_q != '0) begin
          remain_d = remain_q - 1'b1;
        end else begin
          done_d = done_q + 8'd1;
          // Back-to-back chaining: the next command starts with no HOLD gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            b_d      = head_op;
            remain_d = head_remain;
          end else begin
            state_d = ST_IDLE;
            b_d     = OP_HOLD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        b_d     = OP_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      b_q      <= OP_HOLD;
      remain_q <= '0;
      done_q   <= '0;
      expq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      expq_q   <= expq_d;
    end
  end

  assign b1       = b_q[0];
  assign b2       = b_q[1];
  assign busy     = (state_q == ST_DRIVE);
  assign exp_q    = expq_q;
  assign done_cnt = done_q;

endmodule

// File: tb/tb_flip_cmd_seq.sv
// Self-checking bench for flip_cmd_seq: queue-based reference model with a
// per-cycle comparator, plus directed scenarios with literal expectations.
module tb_flip_cmd_seq;
  import flip_cmd_pkg::*;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic       clk;
  logic       rst;
  logic       b1, b2, busy, exp_q;
  logic [7:0] done_cnt;

  int total;
  int bad;

  flip_cmd_seq_if #(.LEN_W(LEN_W)) cif ();

  flip_cmd_seq #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cif.slave),
    .b1       (b1),
    .b2       (b2),
    .busy     (busy),
    .exp_q    (exp_q),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a command list, cycles left on the active command,
  // and the flip stage's q2 driven by the modelled control pair.
  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  cmd_t       mq[$];
  logic [1:0] m_b;
  int         m_left;
  int         m_done;
  int         m_acc;
  logic       m_q;

  always @(posedge clk or posedge rst) begin : model
    bit   can_push;
    bit   can_pop;
    cmd_t c;
    if (rst) begin
      mq.delete();
      m_b    = 2'b00;
      m_left = 0;
      m_done = 0;
      m_acc  = 0;
      m_q    = 1'b0;
    end else begin
      can_push = cif.cmd_valid && (mq.size() < DEPTH);
      can_pop  = (mq.size() > 0);
      m_q = flip_next(m_q, m_b[0], m_b[1]);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done++;
      end
      if (m_left == 0) begin
        if (can_pop) begin
          c      = mq.pop_front();
          m_b    = c.op;
          m_left = (c.len == 0) ? 1 : int'(c.len);
        end else begin
          m_b = 2'b00;
        end
      end
      if (can_push) begin
        mq.push_back({cif.cmd_op, cif.cmd_len});
        m_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("b2b1",      {30'd0, b2, b1},        {30'd0, m_b});
      check("exp_q",     {31'd0, exp_q},         {31'd0, m_q});
      check("busy",      {31'd0, busy},          {31'd0, (m_left > 0)});
      check("done_cnt",  {24'd0, done_cnt},      {24'd0, 8'(m_done)});
      check("cmd_ready", {31'd0, cif.cmd_ready}, {31'd0, (mq.size() < DEPTH)});
    end
  end

  task automatic push(input logic [1:0] op, input logic [LEN_W-1:0] len);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_len   = len;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (mq.size() == 0 && m_left == 0 && !busy) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got busy=%0b want idle within %0d cycles", busy, limit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_len   = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_b",     {30'd0, b2, b1}, 32'd0);
      check("idle_expq",  {31'd0, exp_q}, 32'd0);
      check("idle_ready", {31'd0, cif.cmd_ready}, 32'd1);
      check("idle_done",  {24'd0, done_cnt}, 32'd0);
    end

    // LOAD1 len 3, accepted at edge 1
    push(OP_LOAD1, 4'd3);
    check("l1_e1_b", {30'd0, b2, b1}, 32'd0);
    @(negedge clk);
    check("l1_e2_b",    {30'd0, b2, b1}, 32'd3);
    check("l1_e2_expq", {31'd0, exp_q}, 32'd0);
    check("l1_e2_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("l1_e3_b",    {30'd0, b2, b1}, 32'd3);
    check("l1_e3_expq", {31'd0, exp_q}, 32'd1);
    @(negedge clk);
    check("l1_e4_b", {30'd0, b2, b1}, 32'd3);
    @(negedge clk);
    check("l1_e5_b",    {30'd0, b2, b1}, 32'd0);
    check("l1_e5_done", {24'd0, done_cnt}, 32'd1);
    check("l1_e5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("l1_e6_expq", {31'd0, exp_q}, 32'd1);

    // TOGGLE len 0 then TOGGLE len 2, back-to-back
    do_reset();
    push(OP_TOGGLE, 4'd0);
    push(OP_TOGGLE, 4'd2);
    check("tg_e2_b",    {30'd0, b2, b1}, 32'd1);
    check("tg_e2_expq", {31'd0, exp_q}, 32'd0);
    @(negedge clk);
    check("tg_e3_b",    {30'd0, b2, b1}, 32'd1);
    check("tg_e3_expq", {31'd0, exp_q}, 32'd1);
    check("tg_e3_done", {24'd0, done_cnt}, 32'd1);
    @(negedge clk);
    check("tg_e4_b",    {30'd0, b2, b1}, 32'd1);
    check("tg_e4_expq", {31'd0, exp_q}, 32'd0);
    @(negedge clk);
    check("tg_e5_b",    {30'd0, b2, b1}, 32'd0);
    check("tg_e5_expq", {31'd0, exp_q}, 32'd1);
    check("tg_e5_done", {24'd0, done_cnt}, 32'd2);

    // Fill the FIFO behind a LOAD0 len 15 popped at edge 2
    do_reset();
    push(OP_LOAD0, 4'd15);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push(OP_TOGGLE, 4'd1);
      check("fill_ready", {31'd0, cif.cmd_ready}, (k < 3) ? 32'd1 : 32'd0);
    end
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_LOAD1;
    cif.cmd_len   = 4'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_ready", {31'd0, cif.cmd_ready}, 32'd0);
    end
    cif.cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("full_e16_ready", {31'd0, cif.cmd_ready}, 32'd0);
    @(negedge clk);
    check("full_e17_ready", {31'd0, cif.cmd_ready}, 32'd1);
    check("full_e17_done",  {24'd0, done_cnt}, 32'd1);
    drain(100);
    check("full_done", {24'd0, done_cnt}, 32'd5);

    // Reset in the middle of a LOAD1 len 8
    do_reset();
    push(OP_LOAD1, 4'd8);
    repeat (3) @(negedge clk);
    check("mid_b_pre",    {30'd0, b2, b1}, 32'd3);
    check("mid_expq_pre", {31'd0, exp_q}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_b",     {30'd0, b2, b1}, 32'd0);
    check("mid_expq",  {31'd0, exp_q}, 32'd0);
    check("mid_busy",  {31'd0, busy}, 32'd0);
    check("mid_done",  {24'd0, done_cnt}, 32'd0);
    check("mid_ready", {31'd0, cif.cmd_ready}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_b",    {30'd0, b2, b1}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_done", {24'd0, done_cnt}, 32'd0);

    // 300 random accepted pushes
    do_reset();
    begin
      int cyc;
      cyc = 0;
      while (m_acc < 300 && cyc < 20000) begin
        cif.cmd_valid = ($urandom_range(0, 9) < 7);
        cif.cmd_op    = 2'($urandom_range(0, 3));
        cif.cmd_len   = LEN_W'($urandom_range(0, 5));
        @(negedge clk);
        cyc++;
      end
      cif.cmd_valid = 1'b0;
      check("rand_accepted", 32'(m_acc), 32'd300);
    end
    drain(2000);
    check("rand_done",     {24'd0, done_cnt}, 32'd44);
    check("rand_done_mod", {24'd0, done_cnt}, {24'd0, 8'(m_acc)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
